// File: rtl/hvpp_pkg.sv
// rtl/hvpp_pkg.sv - shared op codes, FSM states and control-pin indices for the HVPP sequencer
package hvpp_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_PROG  = 2'd1,
    OP_READ  = 2'd2,
    OP_PAGEL = 2'd3
  } hvpp_op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_GUARD,
    S_WAIT_RDY,
    S_TURN,
    S_SETTLE,
    S_RESP
  } hvpp_state_e;

  // Bit positions inside the {bs2,bs1,xa1,xa0} control nibble
  localparam int CTRL_XA0 = 0;
  localparam int CTRL_XA1 = 1;
  localparam int CTRL_BS1 = 2;
  localparam int CTRL_BS2 = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/avr_hvpp_sequencer_if.sv
// rtl/avr_hvpp_sequencer_if.sv - host command/response bundle between register decoder and sequencer
interface avr_hvpp_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_ctrl;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_ctrl, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ctrl, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/hvpp_sync2.sv
// rtl/hvpp_sync2.sv - two-flop synchroniser for the asynchronous RDY/BSY pin, resets to 0
module hvpp_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/avr_hvpp_sequencer.sv
// rtl/avr_hvpp_sequencer.sv - one HVPP primitive (LOAD/PROG/READ/PAGEL) per host command, owns all pin timing
// HVPP_RDY_TIMEOUT_EN: when defined, the RDY wait aborts after TIMEOUT_CYC cycles and reports rsp_err.
module avr_hvpp_sequencer
  import hvpp_pkg::*;
#(
  parameter int SETUP_CYC   = 2,
  parameter int PULSE_CYC   = 4,
  parameter int HOLD_CYC    = 2,
  parameter int GUARD_CYC   = 8,
  parameter int SETTLE_CYC  = 8,
  parameter int TIMEOUT_CYC = 480000,
  parameter int CNT_W       = 20
) (
  input  logic                   clk,
  input  logic                   rst_n,
  avr_hvpp_sequencer_if.slave    bus,
  output logic                   dut_xa0,
  output logic                   dut_xa1,
  output logic                   dut_bs1,
  output logic                   dut_bs2,
  output logic                   dut_xtal,
  output logic                   dut_pagel,
  output logic                   dut_wr_n,
  output logic                   dut_oe_n,
  output logic [7:0]             dut_data_o,
  output logic                   dut_data_oe,
  input  logic [7:0]             dut_data_i,
  input  logic                   dut_rdy
);

  localparam int MAX_CYC = max_int(max_int(max_int(SETUP_CYC, PULSE_CYC), max_int(HOLD_CYC, GUARD_CYC)),
                                   max_int(SETTLE_CYC, TIMEOUT_CYC));

  if (MAX_CYC >= (1 << CNT_W)) begin : g_cnt_w_too_small
    $error("CNT_W cannot hold the longest timed state");
  end

  hvpp_state_e      state;
  hvpp_op_e         op_q;
  hvpp_op_e         cmd_op_e;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       ctrl_q;
  logic             cmd_ready_q;
  logic             busy_q;
  logic             rsp_valid_q;
  logic [7:0]       rsp_data_q;
  logic             rdy_s;
  logic             done;
  logic             resp_go;

  assign cmd_op_e = hvpp_op_e'(bus.cmd_op);
  assign done     = (cnt == '0);

  hvpp_sync2 u_rdy_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dut_rdy),
    .q     (rdy_s)
  );

`ifdef HVPP_RDY_TIMEOUT_EN
  logic rsp_err_q;
  logic timeout_go;
  assign bus.rsp_err = rsp_err_q;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  assign dut_xa0 = ctrl_q[CTRL_XA0];
  assign dut_xa1 = ctrl_q[CTRL_XA1];
  assign dut_bs1 = ctrl_q[CTRL_BS1];
  assign dut_bs2 = ctrl_q[CTRL_BS2];

  // Every path into RESP is decided here so the response side effects live in one place
  always_comb begin
    resp_go = 1'b0;
`ifdef HVPP_RDY_TIMEOUT_EN
    timeout_go = 1'b0;
`endif
    case (state)
      S_HOLD:   resp_go = done && (op_q != OP_PROG);
      S_GUARD:  resp_go = done && rdy_s;
      S_WAIT_RDY: begin
`ifdef HVPP_RDY_TIMEOUT_EN
        timeout_go = done && !rdy_s;
        resp_go    = rdy_s || timeout_go;
`else
        resp_go    = rdy_s;
`endif
      end
      S_SETTLE: resp_go = done;
      default:  resp_go = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      op_q        <= OP_LOAD;
      cnt         <= '0;
      ctrl_q      <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      dut_xtal    <= 1'b0;
      dut_pagel   <= 1'b0;
      dut_wr_n    <= 1'b1;
      dut_oe_n    <= 1'b1;
      dut_data_o  <= '0;
      dut_data_oe <= 1'b0;
`ifdef HVPP_RDY_TIMEOUT_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      cnt <= cnt - 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= cmd_op_e;
            ctrl_q      <= bus.cmd_ctrl;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (cmd_op_e == OP_READ) begin
              state <= S_TURN;
            end else begin
              state <= S_SETUP;
              cnt   <= CNT_W'(SETUP_CYC - 1);
            end
            if (cmd_op_e == OP_LOAD) begin
              dut_data_o  <= bus.cmd_data;
              dut_data_oe <= 1'b1;
            end
          end
        end
        S_SETUP: begin
          if (done) begin
            state     <= S_PULSE;
            cnt       <= CNT_W'(PULSE_CYC - 1);
            dut_xtal  <= (op_q == OP_LOAD);
            dut_wr_n  <= (op_q != OP_PROG);
            dut_pagel <= (op_q == OP_PAGEL);
          end
        end
        S_PULSE: begin
          if (done) begin
            state     <= S_HOLD;
            cnt       <= CNT_W'(HOLD_CYC - 1);
            dut_xtal  <= 1'b0;
            dut_wr_n  <= 1'b1;
            dut_pagel <= 1'b0;
          end
        end
        S_HOLD: begin
          if (done && op_q == OP_PROG) begin
            state <= S_GUARD;
            cnt   <= CNT_W'(GUARD_CYC - 1);
          end
        end
        S_GUARD: begin
          if (done) begin
            state <= S_WAIT_RDY;
`ifdef HVPP_RDY_TIMEOUT_EN
            cnt   <= CNT_W'(TIMEOUT_CYC - 1);
`endif
          end
        end
        S_WAIT_RDY: begin
          state <= S_WAIT_RDY;
        end
        // One idle cycle with both sides off the bus before /OE opens the DUT drivers
        S_TURN: begin
          state    <= S_SETTLE;
          cnt      <= CNT_W'(SETTLE_CYC - 1);
          dut_oe_n <= 1'b0;
        end
        S_SETTLE: begin
          if (done) begin
            rsp_data_q <= dut_data_i;
          end
        end
        S_RESP: begin
          state       <= S_IDLE;
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          busy_q      <= 1'b0;
`ifdef HVPP_RDY_TIMEOUT_EN
          rsp_err_q   <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase

      if (resp_go) begin
        state       <= S_RESP;
        rsp_valid_q <= 1'b1;
        ctrl_q      <= '0;
        dut_data_oe <= 1'b0;
        dut_oe_n    <= 1'b1;
`ifdef HVPP_RDY_TIMEOUT_EN
        rsp_err_q   <= timeout_go;
`endif
      end
    end
  end

endmodule

// File: tb/tb_avr_hvpp_sequencer.sv
// tb/tb_avr_hvpp_sequencer.sv - directed and randomized checks of avr_hvpp_sequencer against a timing model
module tb_avr_hvpp_sequencer;
  localparam int SETUP_CYC   = 2;
  localparam int PULSE_CYC   = 4;
  localparam int HOLD_CYC    = 2;
  localparam int GUARD_CYC   = 8;
  localparam int SETTLE_CYC  = 8;
  localparam int TIMEOUT_CYC = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       dut_xa0, dut_xa1, dut_bs1, dut_bs2, dut_xtal, dut_pagel, dut_wr_n, dut_oe_n;
  logic [7:0] dut_data_o;
  logic       dut_data_oe;
  logic [7:0] dut_data_i = 8'h00;
  logic       dut_rdy = 1'b1;

  avr_hvpp_sequencer_if bus ();

  avr_hvpp_sequencer #(
    .SETUP_CYC(SETUP_CYC), .PULSE_CYC(PULSE_CYC), .HOLD_CYC(HOLD_CYC), .GUARD_CYC(GUARD_CYC),
    .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC), .CNT_W(20)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .dut_xa0(dut_xa0), .dut_xa1(dut_xa1), .dut_bs1(dut_bs1), .dut_bs2(dut_bs2),
    .dut_xtal(dut_xtal), .dut_pagel(dut_pagel), .dut_wr_n(dut_wr_n), .dut_oe_n(dut_oe_n),
    .dut_data_o(dut_data_o), .dut_data_oe(dut_data_oe), .dut_data_i(dut_data_i), .dut_rdy(dut_rdy)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_fail = 0;

  int         r_lat, r_xtal, r_wr, r_pagel, r_oe, r_first, r_rise;
  bit         r_got, r_err, r_ctrl_ok, r_bus_ok, r_hs_ok;
  logic [7:0] r_rdata, r_exp_rdata;
  logic [7:0] last_rdata = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency from the accept cycle to rsp_valid; d is how long RDY stays low after /WR rises (0 = never low)
  function automatic int exp_lat(input int op, input int d);
    int tail;
    if (op == 2) return 2 + SETTLE_CYC;
    if (op != 1) return 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC;
    tail = (d + 2 > HOLD_CYC + GUARD_CYC) ? d + 2 : HOLD_CYC + GUARD_CYC;
    return 1 + SETUP_CYC + PULSE_CYC + tail;
  endfunction

  // Issue one command from a negedge and observe every cycle until rsp_valid or the budget runs out
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] ctrl, input logic [7:0] data,
                         input int d, input int rd_val, input int budget);
    int         w;
    logic       prev_wr;
    logic [7:0] v;
    w = 0;
    while (!bus.cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_ctrl  = ctrl;
    bus.cmd_data  = data;
    r_lat = -1; r_xtal = 0; r_wr = 0; r_pagel = 0; r_oe = 0; r_first = -1; r_rise = -1;
    r_got = 0; r_err = 0; r_ctrl_ok = 1; r_bus_ok = 1; r_hs_ok = 1; r_rdata = 8'h00;
    prev_wr = 1'b1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      v = (rd_val >= 0) ? 8'(rd_val) : 8'($urandom);
      dut_data_i = v;
      if (n == 1 + SETTLE_CYC) r_exp_rdata = v;
      if (dut_xtal) r_xtal++;
      if (!dut_wr_n) r_wr++;
      if (dut_pagel) r_pagel++;
      if (!dut_oe_n) r_oe++;
      if (r_first < 0 && (dut_xtal || !dut_wr_n || dut_pagel || !dut_oe_n)) r_first = n;
      if (dut_data_oe && !dut_oe_n) r_bus_ok = 0;
      if (prev_wr && !dut_wr_n && d != 0) dut_rdy = 1'b0;
      if (!prev_wr && dut_wr_n) r_rise = n;
      if (r_rise >= 0 && d > 0 && n - r_rise == d - 1) dut_rdy = 1'b1;
      prev_wr = dut_wr_n;
      if (bus.rsp_valid) begin
        r_got = 1; r_lat = n; r_err = bus.rsp_err; r_rdata = bus.rsp_data;
        if ({dut_bs2, dut_bs1, dut_xa1, dut_xa0} != 4'h0) r_ctrl_ok = 0;
        break;
      end
      if ({dut_bs2, dut_bs1, dut_xa1, dut_xa0} != ctrl) r_ctrl_ok = 0;
      if (!bus.busy || bus.cmd_ready) r_hs_ok = 0;
      if (op == 2'd0 && n <= SETUP_CYC + PULSE_CYC + HOLD_CYC && !(dut_data_oe && dut_data_o == data)) r_bus_ok = 0;
      if (op != 2'd0 && dut_data_oe) r_bus_ok = 0;
    end
  endtask

  task automatic check_cmd(input string tag, input int op, input int d);
    check({tag, ".got"}, 32'(r_got), 1);
    check({tag, ".lat"}, r_lat, exp_lat(op, d));
    check({tag, ".err"}, 32'(r_err), 0);
    check({tag, ".ctrl"}, 32'(r_ctrl_ok), 1);
    check({tag, ".bus"}, 32'(r_bus_ok), 1);
    check({tag, ".hs"}, 32'(r_hs_ok), 1);
    check({tag, ".xtal_w"}, r_xtal, (op == 0) ? PULSE_CYC : 0);
    check({tag, ".wr_w"}, r_wr, (op == 1) ? PULSE_CYC : 0);
    check({tag, ".pagel_w"}, r_pagel, (op == 3) ? PULSE_CYC : 0);
    check({tag, ".oe_w"}, r_oe, (op == 2) ? SETTLE_CYC : 0);
    check({tag, ".strobe_at"}, r_first, (op == 2) ? 2 : 1 + SETUP_CYC);
    if (op == 2) last_rdata = r_exp_rdata;
    check({tag, ".rdata"}, r_rdata, last_rdata);
    @(negedge clk);
    check({tag, ".pulse1"}, 32'(bus.rsp_valid), 0);
    check({tag, ".ready"}, 32'(bus.cmd_ready), 1);
  endtask

  initial begin
    int acc, nrsp, last_rsp, pitch_ok, hs_ok, op, d, w;
    bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_ctrl = 4'h0; bus.cmd_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst.ready", 32'(bus.cmd_ready), 1);
    check("rst.busy", 32'(bus.busy), 0);
    check("rst.rsp", {bus.rsp_valid, bus.rsp_err, bus.rsp_data}, 0);
    check("rst.pins", {dut_bs2, dut_bs1, dut_xa1, dut_xa0, dut_xtal, dut_pagel, dut_wr_n, dut_oe_n}, 8'b0000_0011);
    check("rst.data", {dut_data_oe, dut_data_o}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: LOAD with xa1 set
    run_cmd(2'd0, 4'b0010, 8'hA5, 0, -1, 200);
    check_cmd("t1_load", 0, 0);

    // 2: READ of a fixed byte
    run_cmd(2'd2, 4'b0101, 8'h00, 0, 8'h3C, 200);
    check_cmd("t2_read", 2, 0);
    check("t2.rsp_data", last_rdata, 8'h3C);

    // 3: PROG with RDY low 100 cycles after /WR rises
    run_cmd(2'd1, 4'b1000, 8'h11, 100, -1, 400);
    check_cmd("t3_prog", 1, 100);
    check("t3.rise_to_rsp", r_lat - r_rise, 102);

    // 4: RDY stuck low
    dut_rdy = 1'b1;
`ifdef HVPP_RDY_TIMEOUT_EN
    run_cmd(2'd1, 4'b0011, 8'h22, -1, -1, 400);
    check("t4.got", 32'(r_got), 1);
    check("t4.err", 32'(r_err), 1);
    check("t4.lat", r_lat, 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC + GUARD_CYC + TIMEOUT_CYC);
    check("t4.rdata", r_rdata, last_rdata);
    dut_rdy = 1'b1;
    @(negedge clk);
`else
    run_cmd(2'd1, 4'b0011, 8'h22, -1, -1, 10000);
    check("t4.no_rsp", 32'(r_got), 0);
    check("t4.busy", 32'(bus.busy), 1);
    rst_n = 1'b0;
    dut_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    last_rdata = 8'h00;
    @(negedge clk);
`endif

    // 5: cmd_valid held for three back-to-back LOADs
    acc = 0; nrsp = 0; last_rsp = -1; pitch_ok = 1; hs_ok = 1;
    bus.cmd_op = 2'd0; bus.cmd_ctrl = 4'b1001; bus.cmd_data = 8'h5A; bus.cmd_valid = 1'b1;
    for (int n = 0; n < 45; n++) begin
      if (bus.rsp_valid) begin
        if (last_rsp >= 0 && n - last_rsp != exp_lat(0, 0) + 1) pitch_ok = 0;
        last_rsp = n;
        nrsp++;
      end
      if (bus.busy && bus.cmd_ready) hs_ok = 0;
      if (acc == 3) bus.cmd_valid = 1'b0;
      if (bus.cmd_valid && bus.cmd_ready) acc++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    check("t5.accepts", acc, 3);
    check("t5.rsps", nrsp, 3);
    check("t5.pitch", 32'(pitch_ok), 1);
    check("t5.ready_busy", 32'(hs_ok), 1);

    // 6: reset in the middle of the PROG /WR pulse
    bus.cmd_op = 2'd1; bus.cmd_ctrl = 4'hF; bus.cmd_data = 8'h77; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    w = 0;
    while (dut_wr_n && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("t6.in_pulse", 32'(dut_wr_n), 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6.wr_n", 32'(dut_wr_n), 1);
    check("t6.data_oe", 32'(dut_data_oe), 0);
    check("t6.busy", 32'(bus.busy), 0);
    check("t6.ctrl", {dut_bs2, dut_bs1, dut_xa1, dut_xa0}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dut_rdy = 1'b1;
    last_rdata = 8'h00;
    @(negedge clk);
    run_cmd(2'd3, 4'b0110, 8'h00, 0, -1, 200);
    check_cmd("t6_after", 3, 0);

    // Randomized command mix against the latency/width model
    for (int i = 0; i < 24; i++) begin
      op = $urandom_range(0, 3);
      d = (op == 1) ? $urandom_range(0, 30) : 0;
      run_cmd(2'(op), 4'($urandom), 8'($urandom), d, -1, 400);
      check_cmd($sformatf("rnd%0d_op%0d_d%0d", i, op, d), op, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
